// File: rtl/wb_pkg.sv
// Shared writeback definitions: source select encoding,
// load funct3 codes and the default datapath width.
package wb_pkg;

    localparam int DEF_XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extender.sv
// Sub-word load alignment and sign/zero extension.
// Built only when LOAD_EXT_EN is defined.
module load_extender
    import wb_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        // halfword loads ignore offset[0]
        half_sel = offset[1] ? word[31:16] : word[15:0];
        value    = word;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   value = word;
            F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage register, writeback mux and retired-instruction counter.
// Define LOAD_EXT_EN to build sub-word load extension.
module mem_wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             valid_in,
    input  logic             RegWrite_in,
    input  logic [1:0]       MemtoReg_in,
    input  logic [4:0]       WriteRegister_in,
    input  logic [XLEN-1:0]  ALUResult_in,
    input  logic [XLEN-1:0]  MemData_in,
    input  logic [XLEN-1:0]  PCPlus4_in,
    input  logic [2:0]       funct3_in,
    output logic             RegWrite,
    output logic [4:0]       WriteRegister,
    output logic [XLEN-1:0]  WriteData,
    output logic [CNT_W-1:0] instret
);

    logic            valid_q;
    logic            reg_write_q;
    logic [1:0]      mem_to_reg_q;
    logic [4:0]      wr_reg_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] mem_q;
    logic [XLEN-1:0] pc4_q;
    logic [2:0]      funct3_q;
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0] load_val;

    always_ff @(posedge CLK) begin
        if (RESET || Flush) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 2'b00;
            wr_reg_q     <= 5'd0;
            alu_q        <= '0;
            mem_q        <= '0;
            pc4_q        <= '0;
            funct3_q     <= 3'b000;
        end else if (!Stall) begin
            valid_q      <= valid_in;
            reg_write_q  <= RegWrite_in;
            mem_to_reg_q <= MemtoReg_in;
            wr_reg_q     <= WriteRegister_in;
            alu_q        <= ALUResult_in;
            mem_q        <= MemData_in;
            pc4_q        <= PCPlus4_in;
            funct3_q     <= funct3_in;
        end
    end

    // A flush evicts the held instruction, so it retires even under stall
    always_ff @(posedge CLK) begin
        if (RESET) begin
            instret_q <= '0;
        end else if (valid_q && (!Stall || Flush)) begin
            instret_q <= instret_q + 1'b1;
        end
    end

`ifdef LOAD_EXT_EN
    load_extender #(.XLEN(XLEN)) u_ext (
        .word   (mem_q),
        .funct3 (funct3_q),
        .offset (alu_q[1:0]),
        .value  (load_val)
    );
`else
    logic unused_ok;
    assign unused_ok = ^funct3_q;
    assign load_val  = mem_q;
`endif

    always_comb begin
        WriteData = alu_q;
        case (mem_to_reg_q)
            WB_MEM:  WriteData = load_val;
            WB_PC4:  WriteData = pc4_q;
            default: WriteData = alu_q;
        endcase
    end

    assign RegWrite      = valid_q & reg_write_q & (|wr_reg_q);
    assign WriteRegister = wr_reg_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Load expectations follow LOAD_EXT_EN.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Stall;
    logic        Flush;
    logic        valid_in;
    logic        RegWrite_in;
    logic [1:0]  MemtoReg_in;
    logic [4:0]  WriteRegister_in;
    logic [31:0] ALUResult_in;
    logic [31:0] MemData_in;
    logic [31:0] PCPlus4_in;
    logic [2:0]  funct3_in;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RAW = 32'h80F1_7F82;
`ifdef LOAD_EXT_EN
    localparam logic [31:0] E_LB0  = 32'hFFFF_FF82;
    localparam logic [31:0] E_LBU3 = 32'h0000_0080;
    localparam logic [31:0] E_LH2  = 32'hFFFF_80F1;
    localparam logic [31:0] E_LHU0 = 32'h0000_7F82;
`else
    localparam logic [31:0] E_LB0  = RAW;
    localparam logic [31:0] E_LBU3 = RAW;
    localparam logic [31:0] E_LH2  = RAW;
    localparam logic [31:0] E_LHU0 = RAW;
`endif

    mem_wb_stage dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Stall            (Stall),
        .Flush            (Flush),
        .valid_in         (valid_in),
        .RegWrite_in      (RegWrite_in),
        .MemtoReg_in      (MemtoReg_in),
        .WriteRegister_in (WriteRegister_in),
        .ALUResult_in     (ALUResult_in),
        .MemData_in       (MemData_in),
        .PCPlus4_in       (PCPlus4_in),
        .funct3_in        (funct3_in),
        .RegWrite         (RegWrite),
        .WriteRegister    (WriteRegister),
        .WriteData        (WriteData),
        .instret          (instret)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] m,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [2:0] f3);
        valid_in         = v;
        RegWrite_in      = rw;
        MemtoReg_in      = m;
        WriteRegister_in = rd;
        ALUResult_in     = alu;
        PCPlus4_in       = pc4;
        funct3_in        = f3;
    endtask

    initial begin
        RESET      = 1'b1;
        Stall      = 1'b0;
        Flush      = 1'b0;
        MemData_in = RAW;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_wreg", {27'd0, WriteRegister}, 32'd0);
        check("rst_wdata", WriteData, 32'd0);
        check("rst_instret", instret, 32'd0);

        RESET = 1'b0;
        tick();
        check("idle_regwrite", {31'd0, RegWrite}, 32'd0);
        check("idle_wdata", WriteData, 32'd0);
        check("idle_instret", instret, 32'd0);

        drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h0000_1234, 32'h0, 3'b010);
        tick();
        check("alu_regwrite", {31'd0, RegWrite}, 32'd1);
        check("alu_wreg", {27'd0, WriteRegister}, 32'd5);
        check("alu_wdata", WriteData, 32'h0000_1234);
        check("alu_instret", instret, 32'd0);

        drive(1'b1, 1'b1, 2'b10, 5'd0, 32'h0000_DEAD, 32'h100, 3'b010);
        tick();
        check("jal_x0_regwrite", {31'd0, RegWrite}, 32'd0);
        check("jal_wdata", WriteData, 32'h100);
        check("jal_instret", instret, 32'd1);

        drive(1'b1, 1'b1, 2'b01, 5'd7, 32'h1000, 32'h0, 3'b000);
        tick();
        check("lb0_regwrite", {31'd0, RegWrite}, 32'd1);
        check("lb0_wdata", WriteData, E_LB0);
        check("lb0_instret", instret, 32'd2);

        drive(1'b1, 1'b1, 2'b01, 5'd7, 32'h1003, 32'h0, 3'b100);
        tick();
        check("lbu3_wdata", WriteData, E_LBU3);

        drive(1'b1, 1'b1, 2'b01, 5'd7, 32'h1002, 32'h0, 3'b001);
        tick();
        check("lh2_wdata", WriteData, E_LH2);

        drive(1'b1, 1'b1, 2'b01, 5'd7, 32'h1003, 32'h0, 3'b001);
        tick();
        check("lh3_wdata", WriteData, E_LH2);

        drive(1'b1, 1'b1, 2'b01, 5'd7, 32'h1000, 32'h0, 3'b101);
        tick();
        check("lhu0_wdata", WriteData, E_LHU0);

        drive(1'b1, 1'b1, 2'b01, 5'd7, 32'h1001, 32'h0, 3'b010);
        tick();
        check("lw_wdata", WriteData, RAW);
        check("lw_instret", instret, 32'd7);

        drive(1'b1, 1'b1, 2'b11, 5'd9, 32'hAAAA_0001, 32'h200, 3'b010);
        tick();
        check("a_wdata", WriteData, 32'hAAAA_0001);
        check("a_instret", instret, 32'd8);

        Stall = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 5'd10, 32'hBBBB_0002, 32'h300, 3'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_wreg", {27'd0, WriteRegister}, 32'd9);
            check("stall_wdata", WriteData, 32'hAAAA_0001);
            check("stall_regwrite", {31'd0, RegWrite}, 32'd1);
            check("stall_instret", instret, 32'd8);
        end

        Flush = 1'b1;
        tick();
        check("flush_regwrite", {31'd0, RegWrite}, 32'd0);
        check("flush_instret", instret, 32'd9);

        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000);
        tick();
        check("bubble_instret", instret, 32'd9);

        drive(1'b1, 1'b0, 2'b00, 5'd3, 32'h33, 32'h0, 3'b010);
        tick();
        check("store_regwrite", {31'd0, RegWrite}, 32'd0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000);
        tick();
        check("wrap_instret", instret, 32'd0);

        drive(1'b1, 1'b1, 2'b00, 5'd4, 32'h44, 32'h0, 3'b010);
        tick();
        check("d_regwrite", {31'd0, RegWrite}, 32'd1);
        check("d_instret", instret, 32'd0);

        RESET = 1'b1;
        tick();
        check("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("midrst_wdata", WriteData, 32'd0);
        check("midrst_instret", instret, 32'd0);

        RESET = 1'b0;
        tick();
        check("post_rst_regwrite", {31'd0, RegWrite}, 32'd1);
        check("post_rst_wdata", WriteData, 32'h44);
        check("post_rst_instret", instret, 32'd0);

        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000);
        tick();
        check("final_instret", instret, 32'd1);
        check("final_regwrite", {31'd0, RegWrite}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
